// File: rtl/seq_div_8by4.sv
// seq_div_8by4: sequential restoring divider, 2W-bit dividend / W-bit divisor.
// Produces a W-bit quotient and remainder after W iterations. The START/READY
// handshake matches the shift-add multiplier so the two can be chained.
// Optional macro SEQDIV_DZ_FLAG_EN adds a DZ divide-by-zero flag and forces
// REM to 0 on a divide-by-zero load.
module seq_div_8by4 #(
  parameter int W = 4
) (
  input  logic           CK,
  input  logic           RN,
  input  logic           START,
  input  logic [2*W-1:0] DIVD,
  input  logic [W-1:0]   DIVS,
  output logic [W-1:0]   QUO,
  output logic [W-1:0]   REM,
  output logic           OVF,
  output logic           READY
`ifdef SEQDIV_DZ_FLAG_EN
  ,
  output logic           DZ
`endif
);

  // One extra counter bit so the count can reach W without wrapping.
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  rem_q, qsh_q, dsr_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;

  // Load-edge decode.
  logic [W-1:0]  hi, lo, rem_ld;
  logic          dz_ld, ovf_ld;

  // One restoring iteration.
  logic [W:0]    t, diff;
  logic          ge;
  logic          last_iter;

  assign hi     = DIVD[2*W-1:W];
  assign lo     = DIVD[W-1:0];
  assign dz_ld  = (DIVS == '0);
  // Quotient fits in W bits only if the high half is strictly below the divisor.
  assign ovf_ld = dz_ld || (hi >= DIVS);
`ifdef SEQDIV_DZ_FLAG_EN
  assign rem_ld = dz_ld ? '0 : hi;
`else
  assign rem_ld = hi;
`endif

  // rem < dsr holds in RUN, so the shifted partial remainder fits in W+1 bits.
  assign t         = {rem_q, qsh_q[W-1]};
  assign diff      = t - {1'b0, dsr_q};
  assign ge        = (t >= {1'b0, dsr_q});
  assign last_iter = (cnt_q == CW'(W - 1));

  // State register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: START restarts from any state; RUN ends after the W-th step.
  always_comb begin
    state_nxt = state;
    if (START) begin
      state_nxt = ovf_ld ? DONE : RUN;
    end else if (state == RUN && last_iter) begin
      state_nxt = DONE;
    end
  end

  // Datapath: operand load, overflow result, or one shift/subtract step.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      rem_q <= '0;
      qsh_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (START) begin
      dsr_q <= DIVS;
      cnt_q <= '0;
      if (ovf_ld) begin
        rem_q <= rem_ld;
        qsh_q <= '1;
        ovf_q <= 1'b1;
      end else begin
        rem_q <= hi;
        qsh_q <= lo;
        ovf_q <= 1'b0;
      end
    end else if (state == RUN) begin
      rem_q <= ge ? diff[W-1:0] : t[W-1:0];
      qsh_q <= {qsh_q[W-2:0], ge};
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef SEQDIV_DZ_FLAG_EN
  logic dz_q;

  // Divide-by-zero flag, captured on the load edge and held like OVF.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN)        dz_q <= 1'b0;
    else if (START) dz_q <= dz_ld;
  end

  assign DZ = dz_q;
`endif

  // Outputs: the quotient shift register doubles as the QUO holding register.
  always_comb begin
    READY = (state != RUN);
    QUO   = qsh_q;
    REM   = rem_q;
    OVF   = ovf_q;
  end

endmodule

// File: tb/tb_seq_div_8by4.sv
// Directed bench for seq_div_8by4: reset, normal divisions, overflow and
// divide-by-zero loads, abort by START, abort by reset, continuous START.
module tb_seq_div_8by4;

  logic       CK, RN, START;
  logic [7:0] DIVD;
  logic [3:0] DIVS;
  logic [3:0] QUO, REM;
  logic       OVF, READY;
`ifdef SEQDIV_DZ_FLAG_EN
  logic       DZ;
`endif

  int errors = 0;
  int checks = 0;

  seq_div_8by4 #(.W(4)) dut (
    .CK(CK), .RN(RN), .START(START), .DIVD(DIVD), .DIVS(DIVS),
    .QUO(QUO), .REM(REM), .OVF(OVF), .READY(READY)
`ifdef SEQDIV_DZ_FLAG_EN
    , .DZ(DZ)
`endif
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic [3:0] q,
                         input logic [3:0] r, input logic o);
    chk({tag, ".ready"}, {7'd0, READY}, {7'd0, rdy});
    chk({tag, ".quo"},   {4'd0, QUO},   {4'd0, q});
    chk({tag, ".rem"},   {4'd0, REM},   {4'd0, r});
    chk({tag, ".ovf"},   {7'd0, OVF},   {7'd0, o});
  endtask

  // Load operands for one edge, scramble inputs while busy, count busy cycles.
  task automatic run_div(input string tag, input logic [7:0] dd, input logic [3:0] ds,
                         input logic [3:0] eq, input logic [3:0] er);
    int n;
    DIVD = dd; DIVS = ds; START = 1'b1;
    tick();
    START = 1'b0; DIVD = ~dd; DIVS = ~ds;
    n = 0;
    while (!READY && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".busy"}, 8'(n), 8'd4);
    chk_out(tag, 1'b1, eq, er, 1'b0);
  endtask

  initial begin
    RN = 1'b0; START = 1'b0; DIVD = 8'd0; DIVS = 4'd0;
    #2;
    chk_out("reset", 1'b1, 4'd0, 4'd0, 1'b0);
    #20 RN = 1'b1;
    repeat (3) tick();
    chk_out("idle", 1'b1, 4'd0, 4'd0, 1'b0);

    // 143 / 11 = 13 r 0, held afterwards
    run_div("d143_11", 8'd143, 4'd11, 4'd13, 4'd0);
    repeat (3) tick();
    chk_out("hold", 1'b1, 4'd13, 4'd0, 1'b0);

    run_div("d200_15", 8'd200, 4'd15, 4'd13, 4'd5);
    run_div("d7_3", 8'd7, 4'd3, 4'd2, 4'd1);

    // Overflow: high half 10 >= 10, result on the load edge
    DIVD = 8'hA0; DIVS = 4'd10; START = 1'b1;
    tick();
    START = 1'b0;
    chk_out("ovf", 1'b1, 4'd15, 4'd10, 1'b1);
    tick();
    chk_out("ovf_hold", 1'b1, 4'd15, 4'd10, 1'b1);

    // Divide by zero
    DIVD = 8'h35; DIVS = 4'd0; START = 1'b1;
    tick();
    START = 1'b0;
`ifdef SEQDIV_DZ_FLAG_EN
    chk_out("dz", 1'b1, 4'd15, 4'd0, 1'b1);
    chk("dz.flag", {7'd0, DZ}, 8'd1);
`else
    chk_out("dz", 1'b1, 4'd15, 4'd3, 1'b1);
`endif

    // A normal division clears the overflow flags
    run_div("after_ovf", 8'd7, 4'd3, 4'd2, 4'd1);
`ifdef SEQDIV_DZ_FLAG_EN
    chk("dz.clear", {7'd0, DZ}, 8'd0);
`endif

    // Abort by START: 200/15 replaced by 143/11 two cycles later
    DIVD = 8'd200; DIVS = 4'd15; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    chk("abort.busy", {7'd0, READY}, 8'd0);
    run_div("abort", 8'd143, 4'd11, 4'd13, 4'd0);

    // Abort by asynchronous reset during iteration 2
    DIVD = 8'd143; DIVS = 4'd11; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    #2 RN = 1'b0;
    #1;
    chk_out("rst_abort", 1'b1, 4'd0, 4'd0, 1'b0);
    #4 RN = 1'b1;
    repeat (6) tick();
    chk_out("rst_idle", 1'b1, 4'd0, 4'd0, 1'b0);

    // START held high: keeps reloading, READY stays low
    DIVD = 8'd143; DIVS = 4'd11; START = 1'b1;
    repeat (6) tick();
    chk("held.ready", {7'd0, READY}, 8'd0);
    DIVD = 8'hA0; DIVS = 4'd10;
    tick();
    chk("held.ovf_ready", {7'd0, READY}, 8'd1);
    START = 1'b0;
    run_div("held_done", 8'd143, 4'd11, 4'd13, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
